// File: rtl/fft_spectrum_reader.sv
// fft_spectrum_reader: kicks the FFT, sweeps the magnitude RAM and
// streams bins through a 2-entry buffer with sof/eof and bin index.
module fft_spectrum_reader #(
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 12,
  parameter int NUM_BINS       = 128,
  parameter bit AUTO_RESTART   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trig,
  output logic                      fft_start,
  input  logic                      fft_done,
  input  logic [RAM_ADDR_WIDTH-1:0] peak_bin1_in,
  input  logic [RAM_ADDR_WIDTH-1:0] peak_bin2_in,
  output logic                      ram_ren,
  output logic [RAM_ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0]     ram_rdata,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic [RAM_ADDR_WIDTH-1:0] m_bin,
  output logic                      m_sof,
  output logic                      m_eof,
  output logic [RAM_ADDR_WIDTH-1:0] peak_bin1,
  output logic [RAM_ADDR_WIDTH-1:0] peak_bin2,
  output logic                      busy,
  output logic [15:0]               frame_cnt
);

  localparam int AW = RAM_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    READ,
    DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic          rd_pend;
  logic [AW-1:0] rd_bin;

  logic [DW-1:0] q_data [2];
  logic [AW-1:0] q_bin  [2];
  logic [1:0]    q_sof;
  logic [1:0]    q_eof;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;

  logic          pop;
  logic          issue;
  logic          eof_acc;
  logic [2:0]    level;

  assign m_valid = count != 2'd0;
  assign m_data  = q_data[rd_ptr];
  assign m_bin   = q_bin[rd_ptr];
  assign m_sof   = q_sof[rd_ptr];
  assign m_eof   = q_eof[rd_ptr];

  assign pop     = m_valid & m_ready;
  assign eof_acc = pop & m_eof;

  // Occupancy after this cycle's pop, counting the read in flight.
  assign level = {1'b0, count} + {2'b0, rd_pend} - {2'b0, pop};
  assign issue = (state == READ) && (level < 3'd2);

  assign ram_ren   = issue;
  assign ram_raddr = addr;
  assign busy      = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
        q_bin[i]  <= '0;
      end
      q_sof   <= '0;
      q_eof   <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      rd_pend <= 1'b0;
      rd_bin  <= '0;
    end else begin
      rd_pend <= issue;
      if (issue) rd_bin <= addr;
      if (rd_pend) begin
        q_data[wr_ptr] <= ram_rdata;
        q_bin[wr_ptr]  <= rd_bin;
        q_sof[wr_ptr]  <= rd_bin == '0;
        q_eof[wr_ptr]  <= rd_bin == LAST;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fft_start <= 1'b0;
      addr      <= '0;
      peak_bin1 <= '0;
      peak_bin2 <= '0;
      frame_cnt <= 16'd0;
    end else begin
      fft_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig) begin
            state     <= START;
            fft_start <= 1'b1;
          end
        end
        START: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (fft_done) begin
            state     <= READ;
            peak_bin1 <= peak_bin1_in;
            peak_bin2 <= peak_bin2_in;
          end
        end
        READ: begin
          if (issue && addr == LAST) state <= DRAIN;
        end
        DRAIN: begin
          if (eof_acc) begin
            if (AUTO_RESTART) begin
              state     <= START;
              fft_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (issue) addr <= addr + 1'b1;
      else if (eof_acc) addr <= '0;
      if (eof_acc) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fft_spectrum_reader.sv
// tb_fft_spectrum_reader: directed frames against a mem[a]=3*a RAM,
// plus an AUTO_RESTART instance with a short frame.
module tb_fft_spectrum_reader;

  localparam int AW  = 8;
  localparam int DW  = 12;
  localparam int NB  = 128;
  localparam int NBA = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          trig = 1'b0;
  logic          fft_done = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] pk1_in = '0;
  logic [AW-1:0] pk2_in = '0;
  logic          fft_start, ram_ren, m_valid, m_sof, m_eof, busy;
  logic [AW-1:0] ram_raddr, m_bin, peak_bin1, peak_bin2;
  logic [DW-1:0] ram_rdata, m_data;
  logic [15:0]   frame_cnt;

  logic          a_trig = 1'b0;
  logic          a_fft_done = 1'b0;
  logic          a_m_ready = 1'b0;
  logic          a_fft_start, a_ram_ren, a_m_valid, a_m_sof, a_m_eof;
  logic          a_busy;
  logic [AW-1:0] a_ram_raddr, a_m_bin, a_pk1, a_pk2;
  logic [DW-1:0] a_ram_rdata, a_m_data;
  logic [15:0]   a_frame_cnt;

  fft_spectrum_reader dut (
    .clk(clk), .rst_n(rst_n), .trig(trig),
    .fft_start(fft_start), .fft_done(fft_done),
    .peak_bin1_in(pk1_in), .peak_bin2_in(pk2_in),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_bin(m_bin),
    .m_sof(m_sof), .m_eof(m_eof),
    .peak_bin1(peak_bin1), .peak_bin2(peak_bin2),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  fft_spectrum_reader #(
    .NUM_BINS(NBA), .AUTO_RESTART(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .trig(a_trig),
    .fft_start(a_fft_start), .fft_done(a_fft_done),
    .peak_bin1_in(8'h01), .peak_bin2_in(8'h02),
    .ram_ren(a_ram_ren), .ram_raddr(a_ram_raddr),
    .ram_rdata(a_ram_rdata), .m_valid(a_m_valid),
    .m_ready(a_m_ready), .m_data(a_m_data),
    .m_bin(a_m_bin), .m_sof(a_m_sof), .m_eof(a_m_eof),
    .peak_bin1(a_pk1), .peak_bin2(a_pk2),
    .busy(a_busy), .frame_cnt(a_frame_cnt)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return DW'(int'(a) * 3);
  endfunction

  always @(posedge clk) if (ram_ren) ram_rdata <= mem_val(ram_raddr);
  always @(posedge clk) if (a_ram_ren) a_ram_rdata <= mem_val(a_ram_raddr);

  int checks = 0;
  int failures = 0;

  int            nb;
  logic [DW-1:0] bd [256];
  logic [AW-1:0] bb [256];
  bit            bs [256];
  bit            be [256];
  int c_starts, c_start_cyc, c_done_cyc, c_ren_first;
  int c_first_beat, c_last_beat, c_stall_err, c_ovf_err;
  int c_peak_err, c_raddr_err, c_timeout;
  logic       c_busy_after;
  logic [15:0] c_fc_after;

  task automatic capture(input int pct, input bit noise,
                         input bit pk_mode, input int abort_bin,
                         output bit aborted);
    int issued, accepted;
    bit pv_stall, eof_seen, acc;
    logic [DW+AW+1:0] pv;
    logic [AW-1:0] e1, e2;
    nb = 0; c_starts = 0; c_start_cyc = -1000; c_done_cyc = -1000;
    c_ren_first = -1; c_first_beat = -1; c_last_beat = -1;
    c_stall_err = 0; c_ovf_err = 0; c_peak_err = 0; c_raddr_err = 0;
    c_timeout = 1; c_busy_after = 1'bx; c_fc_after = 'x;
    issued = 0; accepted = 0; pv_stall = 0; pv = '0; eof_seen = 0;
    aborted = 0;
    e1 = pk_mode ? 8'h2A : 8'h33;
    e2 = pk_mode ? 8'h15 : 8'h44;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      trig = (cyc == 0) ||
             (noise && (cyc == c_start_cyc + 3 || cyc == c_done_cyc + 20));
      fft_done = noise && (cyc == c_done_cyc + 40);
      m_ready = ($urandom_range(99) < pct);
      if (pk_mode && c_done_cyc >= 0 && cyc >= c_done_cyc + 5) begin
        pk1_in = 8'h00; pk2_in = 8'h00;
      end else begin
        pk1_in = e1; pk2_in = e2;
      end
      #1;
      if (eof_seen) begin
        c_busy_after = busy; c_fc_after = frame_cnt; c_timeout = 0;
        break;
      end
      acc = m_valid && m_ready;
      if (fft_start) begin
        c_starts++;
        if (c_start_cyc < 0) c_start_cyc = cyc;
        if (noise) fft_done = 1'b1;
      end
      if (cyc == c_start_cyc + 10) begin
        fft_done = 1'b1; c_done_cyc = cyc;
      end
      if (ram_ren) begin
        if (c_ren_first < 0) c_ren_first = cyc;
        if (ram_raddr !== AW'(issued)) c_raddr_err++;
        if (issued - accepted - int'(acc) >= 2) c_ovf_err++;
      end
      if (pv_stall && (!m_valid || {m_data, m_bin, m_sof, m_eof} !== pv))
        c_stall_err++;
      pv_stall = m_valid && !m_ready;
      pv = {m_data, m_bin, m_sof, m_eof};
      if (c_done_cyc >= 0 && cyc > c_done_cyc &&
          (peak_bin1 !== e1 || peak_bin2 !== e2))
        c_peak_err++;
      if (acc && nb < 256) begin
        bd[nb] = m_data; bb[nb] = m_bin; bs[nb] = m_sof; be[nb] = m_eof;
        if (nb == 0) c_first_beat = cyc;
        nb++;
        if (m_eof) begin
          eof_seen = 1; c_last_beat = cyc;
        end
      end
      if (ram_ren) issued++;
      if (acc) accepted++;
      if (abort_bin >= 0 && m_valid && m_bin == AW'(abort_bin)) begin
        rst_n = 1'b0; aborted = 1; c_timeout = 0;
        break;
      end
    end
    trig = 1'b0; fft_done = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({fft_start, ram_ren, m_valid, m_sof, m_eof, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {fft_start, ram_ren, m_valid, m_sof, m_eof, busy});
    end
    checks++;
    if ({ram_raddr, m_bin, peak_bin1, peak_bin2, m_data, frame_cnt}
        !== '0) begin
      failures++;
      $display("FAIL reset_data raddr=%0d bin=%0d p1=%0d p2=%0d d=%0d fc=%0d want=0",
               ram_raddr, m_bin, peak_bin1, peak_bin2, m_data, frame_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || fft_start !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b start=%b want=0 0",
               busy, fft_start);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] fc);
    int seq_err, sof_err, eof_err;
    seq_err = 0; sof_err = 0; eof_err = 0;
    for (int i = 0; i < nb; i++) begin
      if (bb[i] !== AW'(i) || bd[i] !== DW'(3 * i)) seq_err++;
      if (bs[i] !== (i == 0)) sof_err++;
      if (be[i] !== (i == NB - 1)) eof_err++;
    end
    checks++;
    if (c_timeout != 0 || nb != NB) begin
      failures++;
      $display("FAIL %s_beats got=%0d timeout=%0d want=%0d", tag, nb,
               c_timeout, NB);
    end
    checks++;
    if (seq_err != 0) begin
      failures++;
      $display("FAIL %s_sequence errors=%0d want=0", tag, seq_err);
    end
    checks++;
    if (sof_err != 0 || eof_err != 0) begin
      failures++;
      $display("FAIL %s_markers sof_err=%0d eof_err=%0d want=0 0", tag,
               sof_err, eof_err);
    end
    checks++;
    if (c_busy_after !== 1'b0 || c_fc_after !== fc) begin
      failures++;
      $display("FAIL %s_end busy=%b fc=%0d want=0 %0d", tag,
               c_busy_after, c_fc_after, fc);
    end
  endtask

  task automatic test_basic();
    bit ab;
    capture(100, 0, 0, -1, ab);
    check_frame("basic", 16'd1);
    checks++;
    if (c_start_cyc != 1 || c_starts != 1) begin
      failures++;
      $display("FAIL basic_start cyc=%0d n=%0d want=1 1", c_start_cyc,
               c_starts);
    end
    checks++;
    if (c_ren_first != c_done_cyc + 1 || c_first_beat != c_done_cyc + 3)
    begin
      failures++;
      $display("FAIL basic_latency ren=%0d beat=%0d want=%0d %0d",
               c_ren_first, c_first_beat, c_done_cyc + 1, c_done_cyc + 3);
    end
    checks++;
    if (c_last_beat != c_done_cyc + 2 + NB) begin
      failures++;
      $display("FAIL basic_last_beat got=%0d want=%0d", c_last_beat,
               c_done_cyc + 2 + NB);
    end
    checks++;
    if (c_raddr_err != 0 || c_stall_err != 0 || c_ovf_err != 0) begin
      failures++;
      $display("FAIL basic_addr raddr=%0d stall=%0d ovf=%0d want=0",
               c_raddr_err, c_stall_err, c_ovf_err);
    end
  endtask

  task automatic test_backpressure();
    bit ab;
    capture(30, 0, 0, -1, ab);
    check_frame("bp", 16'd2);
    checks++;
    if (c_stall_err != 0) begin
      failures++;
      $display("FAIL bp_stable changes=%0d want=0", c_stall_err);
    end
    checks++;
    if (c_ovf_err != 0 || c_raddr_err != 0) begin
      failures++;
      $display("FAIL bp_overflow ovf=%0d raddr=%0d want=0 0", c_ovf_err,
               c_raddr_err);
    end
  endtask

  task automatic test_peak();
    bit ab;
    capture(100, 0, 1, -1, ab);
    check_frame("peak", 16'd3);
    checks++;
    if (c_peak_err != 0) begin
      failures++;
      $display("FAIL peak_hold errors=%0d want=0", c_peak_err);
    end
    checks++;
    if (peak_bin1 !== 8'h2A || peak_bin2 !== 8'h15) begin
      failures++;
      $display("FAIL peak_after p1=%h p2=%h want=2a 15", peak_bin1,
               peak_bin2);
    end
  endtask

  task automatic test_trig_ignore();
    bit ab;
    capture(100, 1, 0, -1, ab);
    check_frame("trig", 16'd4);
    checks++;
    if (c_starts != 1) begin
      failures++;
      $display("FAIL trig_starts got=%0d want=1", c_starts);
    end
    checks++;
    if (c_ren_first != c_done_cyc + 1) begin
      failures++;
      $display("FAIL trig_early_done ren=%0d want=%0d", c_ren_first,
               c_done_cyc + 1);
    end
    checks++;
    if (c_peak_err != 0) begin
      failures++;
      $display("FAIL trig_peak_update errors=%0d want=0", c_peak_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ab;
    capture(100, 0, 0, 60, ab);
    #1;
    checks++;
    if (ab !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reach got=%b want=1", ab);
    end
    checks++;
    if ({fft_start, ram_ren, m_valid, m_sof, m_eof, busy, ram_raddr,
         m_data, m_bin, peak_bin1, peak_bin2, frame_cnt} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs v=%b bin=%0d d=%0d fc=%0d want=0",
               m_valid, m_bin, m_data, frame_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    capture(100, 0, 0, -1, ab);
    check_frame("fresh", 16'd1);
    checks++;
    if (nb < 1 || bb[0] !== '0 || bs[0] !== 1'b1) begin
      failures++;
      $display("FAIL fresh_first bin=%0d sof=%b want=0 1", bb[0], bs[0]);
    end
  endtask

  task automatic test_auto_restart();
    int done_at, last_eof, eofs, starts, restart_ok, seq_err, k;
    bit fin;
    logic [15:0] fc;
    done_at = -1; last_eof = -100; eofs = 0; starts = 0;
    restart_ok = 0; seq_err = 0; k = 0; fin = 0; fc = 'x;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      a_trig = (cyc == 0);
      a_fft_done = (cyc == done_at);
      a_m_ready = 1'b1;
      #1;
      if (a_fft_start) begin
        starts++;
        if (last_eof == cyc - 1) restart_ok++;
        done_at = cyc + 3;
      end
      if (eofs == 3 && last_eof == cyc - 1) begin
        fc = a_frame_cnt; fin = 1;
      end
      if (a_m_valid && a_m_ready) begin
        if (a_m_bin !== AW'(k % NBA) || a_m_data !== DW'(3 * (k % NBA)))
          seq_err++;
        k++;
        if (a_m_eof) begin
          eofs++; last_eof = cyc;
        end
      end
    end
    a_trig = 1'b0; a_fft_done = 1'b0;
    checks++;
    if (!fin || eofs != 3 || k != 3 * NBA) begin
      failures++;
      $display("FAIL auto_frames fin=%b eofs=%0d beats=%0d want=1 3 %0d",
               fin, eofs, k, 3 * NBA);
    end
    checks++;
    if (restart_ok != 3 || starts != 4) begin
      failures++;
      $display("FAIL auto_restart ok=%0d starts=%0d want=3 4", restart_ok,
               starts);
    end
    checks++;
    if (fc !== 16'd3 || seq_err != 0) begin
      failures++;
      $display("FAIL auto_count fc=%0d seq_err=%0d want=3 0", fc, seq_err);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_peak();
    test_trig_ignore();
    test_reset_mid();
    test_auto_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
